// File: rtl/agu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : agu_pkg                                                   |
// | Brief    : Shared widths, state encoding and base-address helper     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package agu_pkg;

    localparam int ADDR_W     = 48;
    localparam int CNT_W      = 32;
    localparam int WORD_SHIFT = 3;
    localparam int LINE_SHIFT = 6;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_RUN  = 2'd1;
    localparam state_t c_DONE = 2'd2;

    // Port base: MC/port identity selects a 64-byte line, INIT adds an 8-byte word offset.
    function automatic logic [ADDR_W-1:0] port_base(
        input logic [1:0] aeid,
        input logic       oddeven,
        input logic [2:0] peid,
        input logic [5:0] init
    );
        logic [ADDR_W-1:0] w_line;
        logic [ADDR_W-1:0] w_word;
        w_line = ADDR_W'({aeid, oddeven, peid, {LINE_SHIFT{1'b0}}});
        w_word = ADDR_W'({init, {WORD_SHIFT{1'b0}}});
        return w_line + w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/agu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : agu                                                       |
// | Brief    : Per-port strided stream address generator                 |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module agu #(
    parameter int ADDR_W = 48,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [CNT_W-1:0]  PSIZE,
    input  logic [1:0]        AEID,
    input  logic [2:0]        PEID,
    input  logic              ODDEVEN,
    input  logic [63:0]       AEREG,
    input  logic [5:0]        INIT,
    input  logic              MC_RQ_STALL,
    input  logic              FIFO_STALL,
    output logic [ADDR_W-1:0] MC_RQ_ADDR,
    output logic              MC_RQ_EN,
    output logic              FIFO_POP,
    output logic              FINISH
);
    import agu_pkg::*;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_psize;

    logic              w_issue;
    logic              w_last;
    logic [ADDR_W-1:0] w_base;
    logic              w_aereg_unused;

    assign w_aereg_unused = ^AEREG[63:ADDR_W];

    assign w_base  = ADDR_W'(port_base(AEID, ODDEVEN, PEID, INIT));
    assign w_issue = (r_state == c_RUN) && !RST && !MC_RQ_STALL && !FIFO_STALL;
    assign w_last  = (r_count == (r_psize - CNT_W'(1)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= c_IDLE;
            r_addr   <= '0;
            r_stride <= '0;
            r_count  <= '0;
            r_psize  <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (START) begin
                        r_addr   <= w_base;
                        r_stride <= AEREG[ADDR_W-1:0];
                        r_psize  <= PSIZE;
                        r_count  <= '0;
                        r_state  <= (PSIZE == '0) ? c_DONE : c_RUN;
                    end
                end
                c_RUN: begin
                    // Stalled cycles hold address and count so the same request is retried.
                    if (w_issue) begin
                        r_addr  <= r_addr + r_stride;
                        r_count <= r_count + CNT_W'(1);
                        if (w_last) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign MC_RQ_EN   = w_issue;
    assign FIFO_POP   = w_issue;
    assign MC_RQ_ADDR = RST ? '0 : r_addr;
    assign FINISH     = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_agu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_agu                                                    |
// | Brief    : Scoreboard bench for the stream address generator         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_agu;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [31:0] PSIZE;
    logic [1:0]  AEID;
    logic [2:0]  PEID;
    logic        ODDEVEN;
    logic [63:0] AEREG;
    logic [5:0]  INIT;
    logic        MC_RQ_STALL;
    logic        FIFO_STALL;
    logic [47:0] MC_RQ_ADDR;
    logic        MC_RQ_EN;
    logic        FIFO_POP;
    logic        FINISH;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          launch_cyc = 0;
    int          n_issue = 0;
    logic [47:0] sb_q[$];

    agu #(.ADDR_W(48), .CNT_W(32)) u_dut (
        .CLK(CLK), .RST(RST), .START(START), .PSIZE(PSIZE), .AEID(AEID),
        .PEID(PEID), .ODDEVEN(ODDEVEN), .AEREG(AEREG), .INIT(INIT),
        .MC_RQ_STALL(MC_RQ_STALL), .FIFO_STALL(FIFO_STALL),
        .MC_RQ_ADDR(MC_RQ_ADDR), .MC_RQ_EN(MC_RQ_EN), .FIFO_POP(FIFO_POP),
        .FINISH(FINISH)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor: every issue must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (RST || MC_RQ_STALL || FIFO_STALL)
            check("en_gated", {63'b0, MC_RQ_EN}, 64'd0);
        check("pop_eq_en", {63'b0, FIFO_POP}, {63'b0, MC_RQ_EN});
        if (MC_RQ_EN) begin
            n_issue = n_issue + 1;
            check("issue_expected", {63'b0, (sb_q.size() > 0)}, 64'd1);
            if (sb_q.size() > 0)
                check("addr", {16'b0, MC_RQ_ADDR}, {16'b0, sb_q.pop_front()});
        end
    end

    task automatic launch(input logic [1:0] aeid, input logic oe, input logic [2:0] peid,
                          input logic [5:0] init, input logic [47:0] stride, input int psize);
        logic [47:0] base;
        base = 48'({aeid, oe, peid, 6'b0}) + 48'({init, 3'b0});
        AEID = aeid; ODDEVEN = oe; PEID = peid; INIT = init;
        AEREG = {16'hBEEF, stride}; PSIZE = psize; START = 1'b1;
        for (int k = 0; k < psize; k++)
            sb_q.push_back(base + 48'(k) * stride);
        launch_cyc = cyc;
        @(negedge CLK);
        check("no_issue_on_start", {63'b0, MC_RQ_EN}, 64'd0);
        @(posedge CLK); #1;
        START = 1'b0;
        PSIZE = $urandom; AEREG = {$urandom, $urandom}; INIT = 6'($urandom);
        AEID = 2'($urandom); PEID = 3'($urandom); ODDEVEN = 1'($urandom);
        check("finish_after_start", {63'b0, FINISH}, {63'b0, (psize == 0)});
    endtask

    task automatic wait_finish(input int exp_lat);
        int lat;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            if (FINISH) break;
        end
        lat = cyc - launch_cyc;
        check("finish_seen", {63'b0, FINISH}, 64'd1);
        check("finish_latency", 64'(lat), 64'(exp_lat));
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("finish_held", {63'b0, FINISH}, 64'd1);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        int n0;
        RST = 1'b1; START = 1'b0; PSIZE = '0; AEID = '0; PEID = '0; ODDEVEN = 1'b0;
        AEREG = '0; INIT = '0; MC_RQ_STALL = 1'b0; FIFO_STALL = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_finish", {63'b0, FINISH}, 64'd0);
        check("rst_en", {63'b0, MC_RQ_EN}, 64'd0);
        check("rst_addr", {16'b0, MC_RQ_ADDR}, 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Basic run
        launch(2'd1, 1'b1, 3'd3, 6'd0, 48'd64, 4);
        wait_finish(5);

        // Back-pressure from both stall sources
        launch(2'd1, 1'b1, 3'd3, 6'd0, 48'd64, 4);
        @(posedge CLK); #1; MC_RQ_STALL = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1; MC_RQ_STALL = 1'b0; FIFO_STALL = 1'b1;
        @(posedge CLK); #1; FIFO_STALL = 1'b0;
        wait_finish(8);

        // INIT offset, then empty run
        launch(2'd0, 1'b0, 3'd0, 6'd5, 48'd8, 3);
        wait_finish(4);
        launch(2'd0, 1'b0, 3'd0, 6'd5, 48'd8, 0);
        wait_finish(1);

        // Reset mid-run
        n0 = n_issue;
        launch(2'd1, 1'b1, 3'd3, 6'd0, 48'd64, 100);
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (n_issue - n0 >= 10) break;
        end
        check("ten_issues", 64'(n_issue - n0), 64'd10);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_en", {63'b0, MC_RQ_EN}, 64'd0);
        check("midrst_pop", {63'b0, FIFO_POP}, 64'd0);
        check("midrst_finish", {63'b0, FINISH}, 64'd0);
        check("midrst_addr", {16'b0, MC_RQ_ADDR}, 64'd0);
        sb_q.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("post_rst_idle", {63'b0, MC_RQ_EN | FINISH}, 64'd0);
        end
        @(posedge CLK); #1;
        launch(2'd1, 1'b1, 3'd3, 6'd0, 48'd64, 2);
        wait_finish(3);

        // START during RUN is ignored; relaunch from DONE
        launch(2'd2, 1'b0, 3'd5, 6'd1, 48'd64, 4);
        START = 1'b1; PSIZE = 32'd9; INIT = 6'd7; AEREG = 64'h40;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_finish(5);
        launch(2'd2, 1'b0, 3'd5, 6'd1, 48'h1000, 2);
        wait_finish(3);

        // Address wrap modulo 2^48
        launch(2'd0, 1'b0, 3'd0, 6'd0, 48'hFFFF_FFFF_FFC0, 3);
        wait_finish(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/agu.md
Name: agu

Overview:
- Per-port stream address generator for one memory-controller port.
- After a START pulse it issues PSIZE 8-byte requests, one per issuing cycle. Addresses begin at a per-port base and advance by a programmable byte stride.
- Each issue is gated by memory-controller back-pressure and by a data-FIFO stall. Every accepted request also pops the paired stream FIFO.
- Sixteen instances sit in the AE address-generation wrapper. Even instances drive loads, odd instances drive stores. The wrapper adds the region base address and registers the outputs.

Parameters:
- ADDR_W, 48, request address width.
- CNT_W, 32, request counter width (same as PSIZE).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- START  in  1  one-cycle start pulse.
- PSIZE  in  32  number of requests to issue.
- AEID  in  2  application-engine index.
- PEID  in  3  memory-controller index within the AE.
- ODDEVEN  in  1  port parity (selects the even/odd half of the MC).
- AEREG  in  64  bits [47:0] are the byte stride; bits [63:48] are ignored.
- INIT  in  6  starting 8-byte word offset.
- MC_RQ_STALL  in  1  memory-controller request stall.
- FIFO_STALL  in  1  stream FIFO not ready (full for reads, empty for writes).
- MC_RQ_ADDR  out  48  current request byte offset.
- MC_RQ_EN  out  1  request valid/issue.
- FIFO_POP  out  1  stream FIFO pop.
- FINISH  out  1  all requests issued.

Behaviour:
- Reset:
  - One clock, CLK; RST is synchronous and active-high.
  - While RST=1: state=IDLE, address register=0, count=0, FINISH=0.
  - While RST=1, MC_RQ_EN and FIFO_POP are forced to 0 in that same cycle. This holds even if state was RUN.
  - Reset mid-run aborts the run; no further requests are issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - On START=1, latch the run context:
    - base = {AEID, ODDEVEN, PEID, 6'b0} + {INIT, 3'b0}, zero-extended to 48 bits;
    - stride = AEREG[47:0];
    - psize_q = PSIZE.
  - Then set addr = base and count = 0.
  - Next state is RUN, or DONE directly if PSIZE == 0.
- RUN:
  - issue = !RST && !MC_RQ_STALL && !FIFO_STALL. This is combinational; there is no extra latency.
  - MC_RQ_EN = FIFO_POP = issue.
  - MC_RQ_ADDR = addr register; it is valid whenever MC_RQ_EN=1.
  - On issue:
    - addr <= addr + stride, modulo 2^48;
    - count <= count + 1.
  - If count == psize_q - 1 on issue, the next state is DONE.
  - If either stall is high, addr and count hold and no request is issued. The address is retried unchanged on the next free cycle.
- DONE:
  - FINISH=1; it is a level, held until RST or a new START.
  - MC_RQ_EN=0, FIFO_POP=0.
  - START in DONE relaunches exactly as from IDLE, with FINISH=0 from the next cycle.
- Ignored inputs:
  - START while in RUN is ignored.
  - PSIZE, AEREG, INIT, AEID, PEID and ODDEVEN changes after START do not affect the current run.
- Timing:
  - The first request can issue at the earliest one cycle after START.
  - FINISH rises in the cycle after the last issue.
  - Exactly psize_q requests are issued per run, regardless of stall pattern.
- Outputs other than FINISH are combinational from registered state plus the two stall inputs and RST. The wrapper provides the output registering.

Decomposition:
- Package agu_pkg: state enum (IDLE, RUN, DONE), ADDR_W=48, CNT_W=32, WORD_SHIFT=3, LINE_SHIFT=6.
- Single flat module; no sub-module is needed. The counter and address adder are inline.

Test Plan:
- Basic run: AEID=1, ODDEVEN=1, PEID=3, INIT=0, AEREG=64, PSIZE=4, no stalls, START pulse → MC_RQ_EN high 4 consecutive cycles with addresses 0x6C0, 0x700, 0x740, 0x780 → FINISH=1 the next cycle, then held.
- Stall handling: same setup, MC_RQ_STALL=1 for cycles 2–3 of the run, then FIFO_STALL=1 for 1 cycle → MC_RQ_EN=0 and address held during stalls → still exactly 4 issues, same addresses, FINISH after the 4th.
- INIT offset and zero PSIZE: INIT=5, AEID=0, ODDEVEN=0, PEID=0, AEREG=8, PSIZE=3 → addresses 0x28, 0x30, 0x38. Then START with PSIZE=0 → no MC_RQ_EN, FINISH=1 one cycle after START.
- Reset mid-run: PSIZE=100, assert RST after 10 issues → MC_RQ_EN=0 in the RST cycle, FINISH=0, MC_RQ_ADDR=0. A new START restarts at base.
- Restart from DONE and START-in-RUN: a START while in RUN has no effect on count or addresses. After FINISH, a START with PSIZE=2, AEREG=0x1000 → FINISH drops, addresses base and base+0x1000, FINISH rises again.
- Wrap: base 0, AEREG=0xFFFF_FFFF_FFC0, PSIZE=3 → addresses 0x0, 0xFFFF_FFFF_FFC0, 0xFFFF_FFFF_FF80 (modulo 2^48).
